// File: rtl/adpll_gain_sched_if.sv
// adpll_gain_sched_if
//   Groups the run request, reference/phase-error inputs and the gain /
//   status outputs of the ADPLL gain scheduler.
//   master : the side driving enable/ref/error (controller or bench)
//   slave  : the gain scheduler itself
interface adpll_gain_sched_if #(
  parameter int ERR_WIDTH = 8
);
  logic                        enable_i;
  logic                        ref_clk_i;
  logic signed [ERR_WIDTH-1:0] error_i;
  logic                        adpll_en_o;
  logic [7:0]                  kp_o;
  logic [7:0]                  ki_o;
  logic                        locked_o;
  logic                        lock_lost_o;
  logic                        timeout_o;
  logic [2:0]                  state_o;

  modport master (
    output enable_i, ref_clk_i, error_i,
    input  adpll_en_o, kp_o, ki_o, locked_o, lock_lost_o, timeout_o, state_o
  );

  modport slave (
    input  enable_i, ref_clk_i, error_i,
    output adpll_en_o, kp_o, ki_o, locked_o, lock_lost_o, timeout_o, state_o
  );
endinterface

// File: rtl/adpll_gain_sched.sv
// adpll_gain_sched
//   Sequences an ADPLL from acquisition (wide gains) through tracking
//   (narrow gains) into lock, based on the phase error sampled on each
//   rising edge of the reference clock.
// Ports
//   fpga_clk_i : system clock, the only clock
//   rst_pbn_i  : asynchronous active-low reset
//   bus        : adpll_gain_sched_if.slave
//                in : enable_i, ref_clk_i, error_i
//                out: adpll_en_o, kp_o, ki_o, locked_o, lock_lost_o,
//                     timeout_o, state_o (all registered)
//
// state   | meaning
// IDLE    | ADPLL disabled, acquisition gains, waiting for enable_i
// ACQUIRE | wide gains, wait for SETTLE_CNT in-bound edges or time out
// TRACK   | narrow gains, wait for LOCK_CNT edges inside lock bound
// LOCKED  | narrow gains, locked_o high, watch for UNLOCK_CNT misses
// RESTART | ADPLL disabled for one cycle after an acquisition timeout
module adpll_gain_sched #(
  parameter int         ERR_WIDTH   = 8,
  parameter logic [7:0] KP_ACQ      = 8'd32,
  parameter logic [7:0] KI_ACQ      = 8'd8,
  parameter logic [7:0] KP_TRK      = 8'd9,
  parameter logic [7:0] KI_TRK      = 8'd1,
  parameter int         ACQ_THRESH  = 16,
  parameter int         LOCK_THRESH = 4,
  parameter int         SETTLE_CNT  = 32,
  parameter int         LOCK_CNT    = 64,
  parameter int         UNLOCK_CNT  = 8,
  parameter int         ACQ_TIMEOUT = 4096
) (
  input logic              fpga_clk_i,
  input logic              rst_pbn_i,
  adpll_gain_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQUIRE = 3'd1,
    S_TRACK   = 3'd2,
    S_LOCKED  = 3'd3,
    S_RESTART = 3'd4
  } state_e;

  localparam int SET_W  = $clog2(SETTLE_CNT + 1);
  localparam int LCK_W  = $clog2(LOCK_CNT + 1);
  localparam int MIS_W  = $clog2(UNLOCK_CNT + 1);
  localparam int EDG_W  = $clog2(ACQ_TIMEOUT + 1);

  localparam logic [SET_W-1:0] SET_TC  = SET_W'(SETTLE_CNT);
  localparam logic [SET_W-1:0] SET_ONE = SET_W'(1);
  localparam logic [LCK_W-1:0] LCK_TC  = LCK_W'(LOCK_CNT);
  localparam logic [LCK_W-1:0] LCK_ONE = LCK_W'(1);
  localparam logic [MIS_W-1:0] MIS_TC  = MIS_W'(UNLOCK_CNT);
  localparam logic [MIS_W-1:0] MIS_ONE = MIS_W'(1);
  localparam logic [EDG_W-1:0] EDG_TC  = EDG_W'(ACQ_TIMEOUT);
  localparam logic [EDG_W-1:0] EDG_ONE = EDG_W'(1);

  localparam logic [ERR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = ~ERR_MIN;
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ACQ_TH  = ERR_WIDTH'(ACQ_THRESH);
  localparam logic [ERR_WIDTH-1:0] LOCK_TH = ERR_WIDTH'(LOCK_THRESH);

  state_e               state_q, state_d;
  logic                 ref_q;
  logic [SET_W-1:0]     settle_q, settle_d, settle_inc;
  logic [LCK_W-1:0]     lock_q, lock_d, lock_inc;
  logic [MIS_W-1:0]     miss_q, miss_d, miss_inc;
  logic [EDG_W-1:0]     edge_q, edge_d, edge_inc;
  logic                 adpll_en_q, adpll_en_d;
  logic [7:0]           kp_q, kp_d, ki_q, ki_d;
  logic                 locked_q, locked_d;
  logic                 lock_lost_q, lock_lost_d;
  logic                 timeout_q, timeout_d;

  logic                 ref_edge;
  logic [ERR_WIDTH-1:0] err_u, abs_err;
  logic                 in_acq, in_lock, trk_gains;

  assign ref_edge = bus.ref_clk_i & ~ref_q;
  assign err_u    = bus.error_i;

  // The most negative code has no positive twin; clamp it to the largest
  // positive magnitude so it still reads as "far out of bound".
  always_comb begin
    if (err_u == ERR_MIN)           abs_err = ERR_MAX;
    else if (err_u[ERR_WIDTH-1])    abs_err = ~err_u + ERR_ONE;
    else                            abs_err = err_u;
  end

  assign in_acq  = (abs_err <= ACQ_TH);
  assign in_lock = (abs_err <= LOCK_TH);

  assign settle_inc = (settle_q == SET_TC) ? settle_q : settle_q + SET_ONE;
  assign lock_inc   = (lock_q   == LCK_TC) ? lock_q   : lock_q   + LCK_ONE;
  assign miss_inc   = (miss_q   == MIS_TC) ? miss_q   : miss_q   + MIS_ONE;
  assign edge_inc   = (edge_q   == EDG_TC) ? edge_q   : edge_q   + EDG_ONE;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    lock_d      = lock_q;
    miss_d      = miss_q;
    edge_d      = edge_q;
    lock_lost_d = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable_i) state_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (ref_edge) begin
          edge_d   = edge_inc;
          settle_d = in_acq ? settle_inc : '0;
          // settling wins over a timeout landing on the same edge
          if (in_acq && (settle_inc == SET_TC)) begin
            state_d = S_TRACK;
          end else if (edge_inc == EDG_TC) begin
            state_d   = S_RESTART;
            timeout_d = 1'b1;
          end
        end
      end
      S_TRACK: begin
        if (ref_edge) begin
          if (!in_acq) begin
            state_d = S_ACQUIRE;
          end else if (in_lock) begin
            lock_d = lock_inc;
            if (lock_inc == LCK_TC) state_d = S_LOCKED;
          end else begin
            lock_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (ref_edge) begin
          if (!in_lock) begin
            miss_d = miss_inc;
            if (miss_inc == MIS_TC) begin
              state_d     = S_ACQUIRE;
              lock_lost_d = 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
      end
      S_RESTART: state_d = S_ACQUIRE;
      default:   state_d = S_IDLE;
    endcase

    // every state starts with fresh counters
    if (state_d != state_q) begin
      settle_d = '0;
      lock_d   = '0;
      miss_d   = '0;
      edge_d   = '0;
    end

    if (!bus.enable_i) begin
      state_d     = S_IDLE;
      settle_d    = '0;
      lock_d      = '0;
      miss_d      = '0;
      edge_d      = '0;
      lock_lost_d = 1'b0;
      timeout_d   = 1'b0;
    end

    // outputs decoded from the next state so they change together with state_o
    adpll_en_d = (state_d == S_ACQUIRE) || (state_d == S_TRACK) || (state_d == S_LOCKED);
    trk_gains  = (state_d == S_TRACK) || (state_d == S_LOCKED);
    kp_d       = trk_gains ? KP_TRK : KP_ACQ;
    ki_d       = trk_gains ? KI_TRK : KI_ACQ;
    locked_d   = (state_d == S_LOCKED);
  end

  always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      state_q     <= S_IDLE;
      ref_q       <= 1'b0;
      settle_q    <= '0;
      lock_q      <= '0;
      miss_q      <= '0;
      edge_q      <= '0;
      adpll_en_q  <= 1'b0;
      kp_q        <= KP_ACQ;
      ki_q        <= KI_ACQ;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= bus.ref_clk_i;
      settle_q    <= settle_d;
      lock_q      <= lock_d;
      miss_q      <= miss_d;
      edge_q      <= edge_d;
      adpll_en_q  <= adpll_en_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.state_o     = state_q;
  assign bus.adpll_en_o  = adpll_en_q;
  assign bus.kp_o        = kp_q;
  assign bus.ki_o        = ki_q;
  assign bus.locked_o    = locked_q;
  assign bus.lock_lost_o = lock_lost_q;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_adpll_gain_sched.sv
// tb_adpll_gain_sched
//   Directed and randomized stimulus for adpll_gain_sched with default
//   parameters. A per-reference-edge model tracks the expected mode and
//   the consecutive-edge count; every cycle all outputs are compared.
module tb_adpll_gain_sched;
  logic clk;
  logic rst_n;

  adpll_gain_sched_if #(.ERR_WIDTH(8)) bus_if ();

  adpll_gain_sched dut (
    .fpga_clk_i (clk),
    .rst_pbn_i  (rst_n),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: 0 idle, 1 acquire, 2 track, 3 locked, 4 restart
  int m_state = 0;
  int m_run   = 0;
  int m_edges = 0;
  bit e_ll    = 1'b0;
  bit e_to    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit trk;
    trk = (m_state == 2) || (m_state == 3);
    chk({tag, ".state"},     32'(bus_if.state_o),     32'(m_state));
    chk({tag, ".adpll_en"},  32'(bus_if.adpll_en_o),  32'(m_state >= 1 && m_state <= 3));
    chk({tag, ".kp"},        32'(bus_if.kp_o),        trk ? 32'd9 : 32'd32);
    chk({tag, ".ki"},        32'(bus_if.ki_o),        trk ? 32'd1 : 32'd8);
    chk({tag, ".locked"},    32'(bus_if.locked_o),    32'(m_state == 3));
    chk({tag, ".lock_lost"}, 32'(bus_if.lock_lost_o), 32'(e_ll));
    chk({tag, ".timeout"},   32'(bus_if.timeout_o),   32'(e_to));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int mag(input int e);
    int a;
    a = (e < 0) ? -e : e;
    return (a > 127) ? 127 : a;
  endfunction

  task automatic go(input int s);
    m_state = s;
    m_run   = 0;
    m_edges = 0;
  endtask

  task automatic model_edge(input int e);
    int a;
    a = mag(e);
    case (m_state)
      1: begin
        m_edges++;
        m_run = (a <= 16) ? m_run + 1 : 0;
        if (m_run >= 32) go(2);
        else if (m_edges >= 4096) begin go(4); e_to = 1'b1; end
      end
      2: begin
        if (a > 16) go(1);
        else if (a <= 4) begin
          m_run++;
          if (m_run >= 64) go(3);
        end else m_run = 0;
      end
      3: begin
        if (a > 4) begin
          m_run++;
          if (m_run >= 8) begin go(1); e_ll = 1'b1; end
        end else m_run = 0;
      end
      default: ;
    endcase
  endtask

  task automatic edge_only(input int e, input string tag);
    bus_if.ref_clk_i = 1'b1;
    bus_if.error_i   = 8'(e);
    model_edge(e);
    tick();
    check_outputs(tag);
    e_ll = 1'b0;
    e_to = 1'b0;
    bus_if.ref_clk_i = 1'b0;
    bus_if.error_i   = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (m_state == 4) go(1);
      tick();
      check_outputs(tag);
    end
  endtask

  task automatic pulse(input int e, input int gap);
    edge_only(e, "edge");
    idle_cycles(gap, "gap");
  endtask

  function automatic int rand_err(input int mode);
    case (mode)
      0:       return int'($urandom_range(8)) - 4;
      1:       return int'($urandom_range(40)) - 20;
      default: return ($urandom_range(9) == 0) ? int'($urandom_range(255)) - 128
                                                : int'($urandom_range(8)) - 4;
    endcase
  endfunction

  initial begin
    rst_n            = 1'b1;
    bus_if.enable_i  = 1'b0;
    bus_if.ref_clk_i = 1'b0;
    bus_if.error_i   = '0;

    // reset and first transition
    #1 rst_n = 1'b0;
    #2 check_outputs("reset");
    @(negedge clk);
    bus_if.enable_i = 1'b1;
    tick();
    check_outputs("rst_hold");
    rst_n = 1'b1;
    go(1);
    tick();
    check_outputs("acq_entry");
    chk("acq_entry_state", 32'(bus_if.state_o), 32'd1);

    // clean acquisition: 32 zero edges to TRACK, 64 more to LOCKED
    for (int i = 0; i < 32; i++) pulse(0, int'($urandom_range(1, 3)));
    chk("track_state", 32'(bus_if.state_o), 32'd2);
    chk("track_kp",    32'(bus_if.kp_o),    32'd9);
    chk("track_ki",    32'(bus_if.ki_o),    32'd1);
    for (int i = 0; i < 64; i++) pulse(0, int'($urandom_range(1, 3)));
    chk("locked_state", 32'(bus_if.state_o),  32'd3);
    chk("locked_flag",  32'(bus_if.locked_o), 32'd1);

    // 7 misses then a good edge keeps lock; 8 misses drop it
    for (int i = 0; i < 7; i++) pulse(10, 1);
    pulse(int'($urandom_range(8)) - 4, 1);
    chk("stay_locked", 32'(bus_if.state_o), 32'd3);
    for (int i = 0; i < 7; i++) pulse(10, 1);
    edge_only(10, "unlock");
    chk("lock_lost_pulse", 32'(bus_if.lock_lost_o), 32'd1);
    chk("unlock_state",    32'(bus_if.state_o),     32'd1);
    chk("unlock_kp",       32'(bus_if.kp_o),        32'd32);
    idle_cycles(1, "unlock_after");
    chk("lock_lost_single", 32'(bus_if.lock_lost_o), 32'd0);

    // randomized error sequences checked against the model
    for (int b = 0; b < 12; b++) begin
      int mode;
      mode = int'($urandom_range(2));
      for (int i = 0; i < 40; i++) pulse(rand_err(mode), int'($urandom_range(1, 3)));
    end

    // most negative error in TRACK counts as out of acquisition bound
    bus_if.enable_i = 1'b0;
    go(0);
    tick();
    check_outputs("disable");
    bus_if.enable_i = 1'b1;
    go(1);
    tick();
    check_outputs("reenable");
    for (int i = 0; i < 32; i++) pulse(int'($urandom_range(32)) - 16, 1);
    chk("pre_min_state", 32'(bus_if.state_o), 32'd2);
    pulse(-128, 1);
    chk("min_err_state", 32'(bus_if.state_o), 32'd1);

    // acquisition timeout, one disabled cycle, then ACQUIRE again
    for (int i = 0; i < 4095; i++) pulse(-100, 1);
    edge_only(-100, "timeout");
    chk("timeout_pulse", 32'(bus_if.timeout_o),  32'd1);
    chk("restart_state", 32'(bus_if.state_o),    32'd4);
    chk("restart_en",    32'(bus_if.adpll_en_o), 32'd0);
    idle_cycles(1, "post_restart");
    chk("reacq_state", 32'(bus_if.state_o),    32'd1);
    chk("reacq_en",    32'(bus_if.adpll_en_o), 32'd1);

    // settling on the 4096th edge wins over the timeout
    for (int i = 0; i < 4064; i++) pulse(-100, 1);
    for (int i = 0; i < 32; i++) pulse(0, 1);
    chk("settle_prio_state", 32'(bus_if.state_o), 32'd2);

    // enable dropped in TRACK
    bus_if.enable_i = 1'b0;
    go(0);
    tick();
    check_outputs("drop_in_track");
    chk("drop_track_state", 32'(bus_if.state_o), 32'd0);
    bus_if.enable_i = 1'b1;
    go(1);
    tick();
    check_outputs("reenable2");

    // enable dropped in RESTART
    for (int i = 0; i < 4095; i++) pulse(-100, 1);
    edge_only(-100, "timeout2");
    chk("restart2_state", 32'(bus_if.state_o), 32'd4);
    bus_if.enable_i = 1'b0;
    go(0);
    tick();
    check_outputs("drop_in_restart");
    chk("drop_restart_en", 32'(bus_if.adpll_en_o), 32'd0);

    // reach LOCKED, then reset between clock edges
    bus_if.enable_i = 1'b1;
    go(1);
    tick();
    check_outputs("reenable3");
    for (int i = 0; i < 96; i++) pulse(0, 1);
    chk("relock_state", 32'(bus_if.state_o), 32'd3);
    #2 rst_n = 1'b0;
    go(0);
    #1 check_outputs("async_rst");
    chk("async_rst_locked", 32'(bus_if.locked_o), 32'd0);
    idle_cycles(2, "rst_held");
    rst_n = 1'b1;
    go(1);
    tick();
    check_outputs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adpll_gain_sched.md
ADPLL_GAIN_SCHED -- requirements
Module: adpll_gain_sched

Interface
REQ-001 SHALL have parameter ERR_WIDTH, default 8, width of signed phase error input.
REQ-002 SHALL have parameter KP_ACQ / KI_ACQ, defaults 8'd32 / 8'd8, acquisition gains.
REQ-003 SHALL have parameter KP_TRK / KI_TRK, defaults 8'd9 / 8'd1, tracking gains.
REQ-004 SHALL have parameter ACQ_THRESH, default 16, |error| bound for acquisition settle; LOCK_THRESH, default 4, |error| bound for lock.
REQ-005 SHALL have parameter SETTLE_CNT, default 32, and LOCK_CNT, default 64, consecutive in-bound ref edges required; UNLOCK_CNT, default 8, consecutive out-of-bound edges to drop lock; ACQ_TIMEOUT, default 4096, ref edges allowed in ACQUIRE.
REQ-006 fpga_clk_i  in  1  system clock (258 MHz domain); only clock.
REQ-007 rst_pbn_i  in  1  reset, asynchronous, active-low.
REQ-008 enable_i  in  1  run request (level, synchronous to fpga_clk_i).
REQ-009 ref_clk_i  in  1  reference clock, synchronous level in fpga_clk_i domain.
REQ-010 error_i  in  ERR_WIDTH  signed two's-complement phase error from ADPLL.
REQ-011 adpll_en_o  out  1  enable to ADPLL.
REQ-012 kp_o / ki_o  out  8 each  gain words to ADPLL.
REQ-013 locked_o  out  1  high only in LOCKED.
REQ-014 lock_lost_o  out  1  one-cycle pulse on LOCKED exit due to error.
REQ-015 timeout_o  out  1  one-cycle pulse on acquisition timeout.
REQ-016 state_o  out  3  current state encoding: IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3, RESTART=4.

Function
REQ-017 SHALL register ref_clk_i once; ref edge = ref_clk_i high and registered copy low; error_i sampled in that cycle only.
REQ-018 SHALL compute |error_i| with -2^(ERR_WIDTH-1) saturating to 2^(ERR_WIDTH-1)-1.
REQ-019 In-bound compares SHALL use <= threshold.
REQ-020 enable_i low SHALL force IDLE next cycle from any state, overriding all other transitions; counters cleared.
REQ-021 IDLE: adpll_en_o=0, kp_o/ki_o = ACQ gains; enable_i high -> ACQUIRE next cycle.
REQ-022 ACQUIRE: adpll_en_o=1, ACQ gains; per ref edge: in-bound(ACQ_THRESH) increments settle counter else clears it; edge count increments.
REQ-023 ACQUIRE -> TRACK when settle counter reaches SETTLE_CNT (transition on the cycle after the SETTLE_CNT-th consecutive in-bound edge).
REQ-024 ACQUIRE -> RESTART when edge count reaches ACQ_TIMEOUT without settling; timeout_o pulses that cycle; settle has priority if both occur on same edge.
REQ-025 RESTART: adpll_en_o=0 for exactly 1 cycle, counters cleared, then ACQUIRE.
REQ-026 TRACK: adpll_en_o=1, TRK gains; in-bound(LOCK_THRESH) edges counted consecutively; LOCK_CNT reached -> LOCKED; edge with |error| > ACQ_THRESH -> ACQUIRE, counters cleared; edges between thresholds clear lock counter only.
REQ-027 LOCKED: adpll_en_o=1, TRK gains, locked_o=1; out-of-bound(LOCK_THRESH) edge increments miss counter, in-bound clears it; miss counter reaching UNLOCK_CNT -> ACQUIRE, lock_lost_o pulses one cycle.
REQ-028 All outputs SHALL be registered; gain change visible the cycle state_o changes.
REQ-029 Counters SHALL saturate, never wrap; widths sized from parameters.

Reset
REQ-030 rst_pbn_i low SHALL asynchronously force IDLE, adpll_en_o=0, kp_o=KP_ACQ, ki_o=KI_ACQ, locked_o=0, pulses 0, all counters 0.
REQ-031 Release is sampled on fpga_clk_i; first transition no earlier than first clock edge after release; reset mid-LOCKED SHALL NOT pulse lock_lost_o.

Verification
REQ-032 Reset, enable_i=1, error_i=0 on every ref edge -> ACQUIRE 1 cycle later, TRACK after 32 edges (kp_o=9, ki_o=1), LOCKED after 64 further edges, locked_o=1.
REQ-033 In LOCKED, error_i=+10 for 8 edges -> lock_lost_o single pulse, state ACQUIRE, kp_o=32; 7 bad then 1 good edge -> stays LOCKED.
REQ-034 ACQUIRE with error_i=-100 constant -> after 4096 edges timeout_o pulse, adpll_en_o low exactly 1 cycle, ACQUIRE re-entered.
REQ-035 error_i=-128 in TRACK -> treated as |127| > 16, returns to ACQUIRE.
REQ-036 enable_i dropped mid-TRACK and mid-RESTART -> IDLE next cycle, adpll_en_o=0, no pulses.
REQ-037 rst_pbn_i asserted between clock edges in LOCKED -> outputs reset immediately, no lock_lost_o pulse.
